// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the execute stage.
// Operands are latched as magnitudes; signs are re-applied in FIN.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             div_zero;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] opnd;

    logic             sgn;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy  = (state != IDLE);
    assign sgn   = op[0];
    assign mag_a = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // Multiply: {acc,sh} is the shifting product, sh starts as the multiplier.
    // Divide: acc is the partial remainder, sh shifts dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : (WIDTH + 1)'(0));
        rem_shift = {acc, sh[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, opnd});
        rem_diff  = rem_shift[WIDTH-1:0] - opnd;
        prod      = {acc, sh};
        prod_fix  = neg_lo ? (~prod + W2'(1)) : prod;
        quot_fix  = div_zero ? {WIDTH{1'b1}} : (neg_lo ? (~sh + WIDTH'(1)) : sh);
        rem_fix   = neg_hi ? (~acc + WIDTH'(1)) : acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            sh       <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !cancel) begin
                        is_div   <= op[1];
                        neg_lo   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi   <= sgn & a[WIDTH-1];
                        div_zero <= op[1] && (b == '0);
                        count    <= '0;
                        acc      <= '0;
                        if (op[1]) begin
                            sh   <= mag_a;
                            opnd <= mag_b;
                        end else begin
                            sh   <= mag_b;
                            opnd <= mag_a;
                        end
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        count <= count + CW'(1);
                        if (is_div) begin
                            acc <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                            sh  <= {sh[WIDTH-2:0], rem_ge};
                        end else begin
                            acc <= mul_sum[WIDTH:1];
                            sh  <= {mul_sum[0], sh[WIDTH-1:1]};
                        end
                        if (count == LAST) state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    if (!cancel) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[W2-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected {hi,lo}; a monitor checks each done.
module tb_muldiv_unit;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] sh_hi = '0;
    logic [31:0] sh_lo = '0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: MIPS HI/LO semantics from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int si, ti, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: p = 64'(x) * 64'(y);
            2'd1: p = 64'(sx * sy);
            2'd2: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else begin
                    si = int'(x);
                    ti = int'(y);
                    q = si / ti;
                    r = si % ti;
                    p = {32'(r), 32'(q)};
                end
            end
        endcase
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    errors++;
                    $display("FAIL result got=%h exp=%h", {hi, lo}, e);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic wr, input logic [31:0] wv);
        int n;
        logic [63:0] res;
        wait_idle();
        @(negedge clk);
        res = model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        lo_we = wr; wdata = wv;
        exp_q.push_back(res);
        if (wr) sh_lo = wv;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 3) begin
                hi_we = 1'b1;
                wdata = $urandom;
            end else begin
                hi_we = 1'b0;
            end
            if (n == WIDTH / 2) check("hold_during_busy", {hi, lo}, {sh_hi, sh_lo});
            @(negedge clk);
        end
        hi_we = 1'b0;
        check("busy_cycles", 64'(n), 64'(WIDTH + 1));
        check("done_pulse", 64'(done), 64'(1));
        {sh_hi, sh_lo} = res;
        @(negedge clk);
        check("done_drop", 64'(done), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [63:0] r1, r2;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {60'(0), busy, done, 2'b00}, 64'(0));
        check("reset_hilo", {hi, lo}, 64'(0));
        reset = 1'b0;
        @(negedge clk);

        issue(2'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, '0);
        issue(2'd0, 32'hFFFF_FFFF, 32'h2, 1'b0, '0);
        issue(2'd3, 32'hFFFF_FFF9, 32'h2, 1'b0, '0);
        issue(2'd2, 32'd100, 32'd7, 1'b0, '0);
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0);
        issue(2'd2, 32'd5, 32'd0, 1'b0, '0);
        issue(2'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, '0);

        // MTHI in IDLE, then MULTU overwrites at completion
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        sh_hi = 32'h1234;
        check("mthi", 64'(hi), 64'h1234);
        issue(2'd0, 32'd3, 32'd4, 1'b0, '0);
        // MTLO in the same cycle as start
        issue(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hCAFE_F00D);

        // Cancel mid-operation
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        check("cancel_hilo", {hi, lo}, {sh_hi, sh_lo});

        // Cancel with start in IDLE
        @(negedge clk);
        start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_start", 64'(busy), 64'(0));

        // start held across busy: relaunch only in the done cycle
        wait_idle();
        @(negedge clk);
        r1 = model(2'd1, 32'd7, 32'hFFFF_FFFE);
        r2 = model(2'd2, 32'd77, 32'd10);
        start = 1'b1; op = 2'd1; a = 32'd7; b = 32'hFFFF_FFFE;
        exp_q.push_back(r1);
        exp_q.push_back(r2);
        @(negedge clk);
        op = 2'd2; a = 32'd77; b = 32'd10;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("held_busy_cycles", 64'(n), 64'(WIDTH + 1));
        check("held_done", 64'(done), 64'(1));
        @(negedge clk);
        start = 1'b0;
        check("held_relaunch", 64'(busy), 64'(1));
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("held_second_done", 64'(done), 64'(1));
        {sh_hi, sh_lo} = r2;

        // Async reset mid-operation
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'h1234_5678; b = 32'h9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_mid_busy", 64'(busy), 64'(0));
        check("reset_mid_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        reset = 1'b0;
        sh_hi = '0; sh_lo = '0;
        repeat (40) @(negedge clk);
        check("reset_no_done_hilo", {hi, lo}, 64'(0));

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), $urandom);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
